// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   UART_DATA_BITS  : default character width, shared with the receiver.
//   uart_rx_entry_t : one received character plus its line-status flags.
//                     Packed layout {frame_err, parity_err, data}. The FIFO
//                     stores entries as flat vectors in the same bit order.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef struct packed {
      logic                      frame_err;
      logic                      parity_err;
      logic [UART_DATA_BITS-1:0] data;
   } uart_rx_entry_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for the receive FIFO.
//   clk_i   : write clock
//   we_i    : write enable, captured on the rising edge
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (asynchronous read)
//   rdata_o : data at raddr_i, combinational
// The contents are not reset; the owner tracks which entries are valid.
module uart_fifo_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 10
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side first-word-fall-through FIFO behind the UART receiver.
//   clk, reset       : clock, asynchronous active-high reset
//   in_data/in_valid : received character and its one-cycle strobe
//   in_parity_err    : parity status stored with the character
//   in_frame_err     : framing status stored with the character
//   out_data/out_*   : head entry, forced to 0 when empty
//   out_valid        : FIFO not empty
//   out_ready        : consumer takes the head entry
//   count/full/empty : occupancy, all decoded from the count register
//   overflow         : sticky, set whenever a character is dropped
//   clear_overflow   : synchronous clear of overflow (a same-cycle drop wins)
//   flush            : synchronous discard of all entries and any same-cycle push
//
// Handshake: an entry transfers on every rising edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready. The input
// side has no backpressure: in_valid is a push request that is either
// stored or dropped (flagged in overflow).
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS,
   parameter int DEPTH     = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_BITS-1:0]   in_data,
   input  logic                   in_valid,
   input  logic                   in_parity_err,
   input  logic                   in_frame_err,
   output logic [DATA_BITS-1:0]   out_data,
   output logic                   out_parity_err,
   output logic                   out_frame_err,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   input  logic                   clear_overflow,
   input  logic                   flush
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DATA_BITS + 2;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          overflow_q, overflow_d;

   logic          push, pop, drop, write_en;
   logic [EW-1:0] wr_entry, rd_entry;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // Popping frees a slot in the same edge, so a full FIFO can still accept.
   assign pop  = !empty && out_ready;
   assign push = in_valid && (!full || pop);
   assign drop = in_valid && full && !pop;

   // Flush discards a same-cycle push, so the array is not written either.
   assign write_en = push && !flush;
   assign wr_entry = {in_frame_err, in_parity_err, in_data};

   uart_fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (write_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_entry)
   );

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end

      // A drop in the same cycle as clear_overflow keeps the flag set.
      if (drop && !flush)      overflow_d = 1'b1;
      else if (clear_overflow) overflow_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign count          = count_q;
   assign overflow       = overflow_q;
   assign out_valid      = !empty;
   assign out_data       = empty ? '0   : rd_entry[DATA_BITS-1:0];
   assign out_parity_err = empty ? 1'b0 : rd_entry[DATA_BITS];
   assign out_frame_err  = empty ? 1'b0 : rd_entry[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

   localparam int DW = 8;
   localparam int EW = DW + 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_parity_err = 1'b0;
   logic          in_frame_err = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_parity_err;
   logic          out_frame_err;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [4:0]    count;
   logic          full;
   logic          empty;
   logic          overflow;
   logic          clear_overflow = 1'b0;
   logic          flush = 1'b0;

   uart_rx_fifo #(.DATA_BITS(DW), .DEPTH(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_parity_err  (in_parity_err),
      .in_frame_err   (in_frame_err),
      .out_data       (out_data),
      .out_parity_err (out_parity_err),
      .out_frame_err  (out_frame_err),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .count          (count),
      .full           (full),
      .empty          (empty),
      .overflow       (overflow),
      .clear_overflow (clear_overflow),
      .flush          (flush)
   );

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp_e;
   logic [EW-1:0] head;
   int vec_cnt = 0;
   int err_cnt = 0;

   assign head = {out_frame_err, out_parity_err, out_data};

   // ---------------- driver tasks ----------------
   // Inputs change on the falling edge; outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_push(input logic [DW-1:0] d, input logic pe, input logic fe);
      in_valid = 1'b1; in_data = d; in_parity_err = pe; in_frame_err = fe;
      step();
      in_valid = 1'b0; in_data = '0; in_parity_err = 1'b0; in_frame_err = 1'b0;
   endtask

   task automatic drive_pop();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic drive_fill(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(base + i);
         step();
      end
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      vec_cnt++; if (count !== 5'd0) begin err_cnt++; $display("FAIL reset_count: got %0d exp 0", count); end
      vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL reset_empty: got %b exp 1", empty); end
      vec_cnt++; if (full !== 1'b0) begin err_cnt++; $display("FAIL reset_full: got %b exp 0", full); end
      vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
      vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
      vec_cnt++; if (head !== 10'h000) begin err_cnt++; $display("FAIL reset_head: got %h exp 000", head); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_basic();
      drive_push(8'h41, 1'b0, 1'b0); exp_q.push_back(10'h041); step();
      drive_push(8'h42, 1'b0, 1'b0); exp_q.push_back(10'h042); step();
      drive_push(8'h43, 1'b0, 1'b0); exp_q.push_back(10'h043); step();
      vec_cnt++; if (count !== 5'd3) begin err_cnt++; $display("FAIL basic_count: got %0d exp 3", count); end
      vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_out_valid: got %b exp 1", out_valid); end
      vec_cnt++; if (out_data !== 8'h41) begin err_cnt++; $display("FAIL basic_head: got %h exp 41", out_data); end
      for (int i = 0; i < 3; i++) begin
         exp_e = exp_q.pop_front();
         vec_cnt++; if (head !== exp_e) begin err_cnt++; $display("FAIL basic_read%0d: got %h exp %h", i, head, exp_e); end
         drive_pop();
      end
      vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL basic_empty: got %b exp 1", empty); end
      // Storage still holds 0x43 at the old slot; empty must force zeros.
      vec_cnt++; if (head !== 10'h000) begin err_cnt++; $display("FAIL basic_empty_head: got %h exp 000", head); end
   endtask

   task automatic test_flags();
      drive_push(8'h55, 1'b1, 1'b0); exp_q.push_back(10'h155);
      drive_push(8'hAA, 1'b0, 1'b1); exp_q.push_back(10'h2AA);
      vec_cnt++; if (count !== 5'd2) begin err_cnt++; $display("FAIL flags_count: got %0d exp 2", count); end
      for (int i = 0; i < 2; i++) begin
         exp_e = exp_q.pop_front();
         vec_cnt++; if (head !== exp_e) begin err_cnt++; $display("FAIL flags_read%0d: got %h exp %h", i, head, exp_e); end
         drive_pop();
      end
      vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL flags_empty: got %b exp 1", empty); end
   endtask

   task automatic test_overflow();
      drive_fill(16, 0);
      for (int i = 0; i < 16; i++) exp_q.push_back(EW'(i));
      vec_cnt++; if (full !== 1'b1) begin err_cnt++; $display("FAIL ovf_full: got %b exp 1", full); end
      vec_cnt++; if (count !== 5'd16) begin err_cnt++; $display("FAIL ovf_count_full: got %0d exp 16", count); end
      vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_before_drop: got %b exp 0", overflow); end
      drive_push(8'hFF, 1'b0, 1'b0);
      vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_set: got %b exp 1", overflow); end
      vec_cnt++; if (count !== 5'd16) begin err_cnt++; $display("FAIL ovf_count_after_drop: got %0d exp 16", count); end
      vec_cnt++; if (head !== 10'h000) begin err_cnt++; $display("FAIL ovf_head: got %h exp 000", head); end
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_clear: got %b exp 0", overflow); end
   endtask

   // Runs on the full FIFO left by test_overflow.
   task automatic test_full_push_pop();
      in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
      step();
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(10'h077);
      vec_cnt++; if (count !== 5'd16) begin err_cnt++; $display("FAIL fpp_count: got %0d exp 16", count); end
      vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL fpp_overflow: got %b exp 0", overflow); end
      for (int i = 0; i < 16; i++) begin
         exp_e = exp_q.pop_front();
         vec_cnt++; if (head !== exp_e) begin err_cnt++; $display("FAIL fpp_read%0d: got %h exp %h", i, head, exp_e); end
         drive_pop();
      end
      vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL fpp_empty: got %b exp 1", empty); end
   endtask

   task automatic test_flush();
      drive_fill(5, 8'h20);
      vec_cnt++; if (count !== 5'd5) begin err_cnt++; $display("FAIL flush_pre_count: got %0d exp 5", count); end
      flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
      step();
      flush = 1'b0; in_valid = 1'b0; in_data = '0;
      vec_cnt++; if (count !== 5'd0) begin err_cnt++; $display("FAIL flush_count: got %0d exp 0", count); end
      vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL flush_empty: got %b exp 1", empty); end
      vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL flush_overflow: got %b exp 0", overflow); end
      drive_push(8'h12, 1'b0, 1'b0);
      vec_cnt++; if (head !== 10'h012) begin err_cnt++; $display("FAIL flush_next_head: got %h exp 012", head); end
      vec_cnt++; if (count !== 5'd1) begin err_cnt++; $display("FAIL flush_next_count: got %0d exp 1", count); end
      drive_pop();
   endtask

   task automatic test_async_reset();
      // Set overflow, then flush: overflow must survive the flush.
      drive_fill(16, 8'h80);
      drive_push(8'hFF, 1'b0, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL arst_flush_keeps_ovf: got %b exp 1", overflow); end
      drive_fill(4, 8'h60);
      vec_cnt++; if (count !== 5'd4) begin err_cnt++; $display("FAIL arst_pre_count: got %0d exp 4", count); end
      #2 reset = 1'b1;
      #1;
      vec_cnt++; if (count !== 5'd0) begin err_cnt++; $display("FAIL arst_count: got %0d exp 0", count); end
      vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL arst_out_valid: got %b exp 0", out_valid); end
      vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL arst_overflow: got %b exp 0", overflow); end
      @(negedge clk);
      reset = 1'b0;
      step();
      drive_push(8'h10, 1'b0, 1'b0);
      vec_cnt++; if (head !== 10'h010) begin err_cnt++; $display("FAIL arst_next_head: got %h exp 010", head); end
      vec_cnt++; if (count !== 5'd1) begin err_cnt++; $display("FAIL arst_next_count: got %0d exp 1", count); end
      drive_pop();
      vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL arst_final_empty: got %b exp 1", empty); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_flags();
      test_overflow();
      test_full_push_pop();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART receiver. It captures each received character plus its parity and framing status on the receiver's one-cycle `data_ready` strobe, and stores them in a first-word-fall-through FIFO. The consumer (bus interface or loopback logic) drains entries through a valid/ready handshake. A sticky overflow flag records every character lost while the FIFO was full.

## Interface
- `DATA_BITS`, default 8: character width; must match the receiver's setting.
- `DEPTH`, default 16: number of entries; a power of two, at least 2.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_data` input DATA_BITS: received character (the receiver's `rx_data`).
- `in_valid` input 1: one push request per high cycle (the receiver's `data_ready`).
- `in_parity_err` input 1: parity status for `in_data`.
- `in_frame_err` input 1: framing status for `in_data`.
- `out_data` output DATA_BITS: head-entry character; 0 when empty.
- `out_parity_err` output 1: head-entry parity flag; 0 when empty.
- `out_frame_err` output 1: head-entry framing flag; 0 when empty.
- `out_valid` output 1: high when the FIFO is not empty.
- `out_ready` input 1: consumer accepts the head entry.
- `count` output $clog2(DEPTH)+1: number of stored entries, 0..DEPTH.
- `full` output 1: `count == DEPTH`.
- `empty` output 1: `count == 0`.
- `overflow` output 1: sticky; set when a push is dropped.
- `clear_overflow` input 1: synchronous clear of `overflow`.
- `flush` input 1: synchronous discard of all entries.

## Operation
- Entry = {`in_frame_err`, `in_parity_err`, `in_data`}, width DATA_BITS+2.
- Pop = `out_valid && out_ready`.
- Push = `in_valid && (!full || pop)`.
- Write and read pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- `count` is held in a register.
  - It increments on push only and decrements on pop only.
  - It is unchanged on a simultaneous push and pop, including when full.
- Drop condition: `in_valid && full && !pop`. On a drop the character is discarded, pointers and `count` are unchanged, and `overflow` is set.
- `overflow` priority: set beats `clear_overflow` in the same cycle. `flush` does not affect `overflow`.
- `flush` has priority over push and pop:
  - Both pointers and `count` go to 0.
  - A same-cycle `in_valid` is discarded and does not set `overflow`.
- Empty FIFO: `out_*` data and flags are forced to 0, and `out_ready` is ignored.
- Stored error flags pass through untouched. The FIFO does not interpret them.

## Timing
- Reset values:
  - `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `out_valid` = 0.
  - `out_data`, `out_parity_err`, `out_frame_err` = 0.
  - Pointers = 0. Storage contents are not reset.
- Reset asserted mid-operation: everything returns to the reset values asynchronously, and stored entries are lost.
- Write latency: a push at edge N makes the entry visible from edge N; `out_valid` is high in the following cycle if the FIFO was empty.
- Read is first-word-fall-through:
  - `out_*` is driven combinationally from storage at the read pointer.
  - After a pop at edge N, the next entry is presented in the following cycle.
- `full`, `empty` and `overflow` are registered or decoded from registers. They have no combinational path from `in_valid`.
- Sustained rate: one push and one pop per cycle.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_entry_t` packed struct {`frame_err`, `parity_err`, `data`}.
  - The DATA_BITS default constant, shared with the receiver.
- One sub-module, `uart_fifo_ram`: a DEPTH×width storage array with a synchronous write port and an asynchronous read port, no reset.
- Pointer, count and flag logic stay in `uart_rx_fifo`.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 on single-cycle strobes with no pops:
  - `count` = 3, `out_valid` = 1, `out_data` = 0x41.
  - Pop three times: the bench reads 0x41, 0x42, 0x43 in order, and `empty` = 1.
- Push 0x55 with `in_parity_err` = 1, then 0xAA with `in_frame_err` = 1: each flag appears only with its own byte at the head.
- Fill all 16 entries with 0x00..0x0F, then push 0xFF:
  - `overflow` = 1, `count` = 16, and 0xFF is never read.
  - Assert `clear_overflow`: `overflow` = 0.
- While full, push 0x77 and pop in the same cycle: `count` stays 16, `overflow` stays 0, and 0x77 is read last.
- With 5 entries stored, assert `flush` together with `in_valid` and `in_data` = 0x99: the next cycle has `count` = 0, `empty` = 1 and `overflow` unchanged.
- Assert `reset` asynchronously mid-stream between clock edges with 4 entries stored: `count`, `out_valid` and `overflow` go to 0 immediately, and the next push of 0x10 reads back as 0x10.
